// File: rtl/lcd_pkg.sv
// Shared constants for the LCD RGB565 output stage: the 4x4 Bayer threshold
// matrix, RGB565 channel widths and the fixed pipeline depth.
// Pure package, no logic.
package lcd_pkg;

    localparam int R_W        = 5;
    localparam int G_W        = 6;
    localparam int B_W        = 5;
    localparam int PIPE_DEPTH = 2;

    // Row-major 4x4 ordered-dither matrix, index = {row, col}
    localparam logic [3:0] BAYER4 [16] = '{
        4'd0,  4'd8,  4'd2,  4'd10,
        4'd12, 4'd4,  4'd14, 4'd6,
        4'd3,  4'd11, 4'd1,  4'd9,
        4'd15, 4'd7,  4'd13, 4'd5
    };

    function automatic logic [3:0] bayer_thr(input logic [1:0] row, input logic [1:0] col);
        return BAYER4[{row, col}];
    endfunction

endpackage

// File: rtl/lcd_dither_chan.sv
// One colour channel: adds the scaled Bayer threshold and truncates to (8-DROP_BITS) bits.
// Latency: 1 cycle (registered output), saturating to all-ones on carry-out.
// No backpressure; blanking (de=0) forces the output to zero.
module lcd_dither_chan #(
    parameter int DROP_BITS = 3
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [7:0]             val,
    input  logic [3:0]             thr,
    input  logic                   de,
    output logic [7-DROP_BITS:0]   result
);

    localparam int OUT_W = 8 - DROP_BITS;
    // Threshold spans 0..15; scale it to one output LSB (0..7 for 5-bit, 0..3 for 6-bit)
    localparam int SHIFT = 4 - DROP_BITS;

    logic [3:0] add;
    logic [8:0] sum;
    logic       unused_sum_lsb;

    assign add            = thr >> SHIFT;
    assign sum            = {1'b0, val} + {5'b0, add};
    assign unused_sum_lsb = ^sum[DROP_BITS-1:0];

    // Output register: zero on reset or blanking, saturate instead of wrapping
    always_ff @(posedge clk) begin
        if (!resetn) begin
            result <= '0;
        end else if (!de) begin
            result <= '0;
        end else if (sum[8]) begin
            result <= {OUT_W{1'b1}};
        end else begin
            result <= sum[7:DROP_BITS];
        end
    end

endmodule

// File: rtl/lcd_rgb565_dither.sv
// RGB888 -> RGB565 output stage with 4x4 Bayer dither; hs/vs/de delayed to stay aligned.
// Latency: 2 pixelClk for every output; one pixel per cycle.
// No backpressure or stall. Optional LCD_DITHER_TEMPORAL_EN shifts the pattern each frame.
module lcd_rgb565_dither
    import lcd_pkg::*;
#(
    parameter bit VS_ACTIVE_LOW = 1'b1,
    parameter bit HS_ACTIVE_LOW = 1'b1,
    parameter int POS_W         = 10
) (
    input  logic             pixelClk,
    input  logic             resetn,
    input  logic             ditherEn,
    input  logic             hs,
    input  logic             vs,
    input  logic             de,
    input  logic [POS_W-1:0] pixelX,
    input  logic [POS_W-1:0] pixelY,
    input  logic [7:0]       r,
    input  logic [7:0]       g,
    input  logic [7:0]       b,
    output logic             lcdHs,
    output logic             lcdVs,
    output logic             lcdDe,
    output logic [R_W-1:0]   lcdR,
    output logic [G_W-1:0]   lcdG,
    output logic [B_W-1:0]   lcdB
);

    // Sync bundle order: {hs, vs, de}; idle = both syncs deasserted, de low
    localparam logic [2:0] SYNC_IDLE = {HS_ACTIVE_LOW, VS_ACTIVE_LOW, 1'b0};

    logic [2:0] sync_pipe [PIPE_DEPTH];
    logic [7:0] r_s1, g_s1, b_s1;
    logic [3:0] thr_s1;
    logic [3:0] thr_next;
    logic [1:0] row_idx, col_idx;
    logic [1:0] off;
    logic       de_s1;
    logic       unused_pos;

    // Only the low two position bits select the matrix cell
    assign unused_pos = ^{pixelX[POS_W-1:2], pixelY[POS_W-1:2]};

`ifdef LCD_DITHER_TEMPORAL_EN
    logic [1:0] frame_cnt;
    logic       vs_on;
    logic       vs_on_prev;

    assign vs_on      = VS_ACTIVE_LOW ? ~vs : vs;
    assign vs_on_prev = VS_ACTIVE_LOW ? ~sync_pipe[0][1] : sync_pipe[0][1];

    // Frame counter advances on each vs assertion edge, regardless of de
    always_ff @(posedge pixelClk) begin
        if (!resetn) begin
            frame_cnt <= 2'd0;
        end else if (vs_on && !vs_on_prev) begin
            frame_cnt <= frame_cnt + 2'd1;
        end
    end

    assign off = frame_cnt;
`else
    assign off = 2'd0;
`endif

    // Matrix cell lookup; 2-bit adds wrap mod 4 so the pattern shifts diagonally
    always_comb begin
        row_idx  = pixelY[1:0] + off;
        col_idx  = pixelX[1:0] + off;
        thr_next = ditherEn ? bayer_thr(row_idx, col_idx) : 4'd0;
    end

    // Stage 1 colour/threshold register
    always_ff @(posedge pixelClk) begin
        if (!resetn) begin
            r_s1   <= 8'd0;
            g_s1   <= 8'd0;
            b_s1   <= 8'd0;
            thr_s1 <= 4'd0;
        end else begin
            r_s1   <= r;
            g_s1   <= g;
            b_s1   <= b;
            thr_s1 <= thr_next;
        end
    end

    // Sync delay line matching the colour pipeline depth
    always_ff @(posedge pixelClk) begin
        if (!resetn) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                sync_pipe[i] <= SYNC_IDLE;
            end
        end else begin
            sync_pipe[0] <= {hs, vs, de};
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                sync_pipe[i] <= sync_pipe[i-1];
            end
        end
    end

    assign de_s1 = sync_pipe[0][0];
    assign lcdHs = sync_pipe[PIPE_DEPTH-1][2];
    assign lcdVs = sync_pipe[PIPE_DEPTH-1][1];
    assign lcdDe = sync_pipe[PIPE_DEPTH-1][0];

    lcd_dither_chan #(.DROP_BITS(8 - R_W)) u_chan_r (
        .clk    (pixelClk),
        .resetn (resetn),
        .val    (r_s1),
        .thr    (thr_s1),
        .de     (de_s1),
        .result (lcdR)
    );

    lcd_dither_chan #(.DROP_BITS(8 - G_W)) u_chan_g (
        .clk    (pixelClk),
        .resetn (resetn),
        .val    (g_s1),
        .thr    (thr_s1),
        .de     (de_s1),
        .result (lcdG)
    );

    lcd_dither_chan #(.DROP_BITS(8 - B_W)) u_chan_b (
        .clk    (pixelClk),
        .resetn (resetn),
        .val    (b_s1),
        .thr    (thr_s1),
        .de     (de_s1),
        .result (lcdB)
    );

endmodule

// File: tb/tb_lcd_rgb565_dither.sv
// Bench for lcd_rgb565_dither: directed vector table, hand sequences, random stream.
// Every cycle the outputs are compared against a behavioural model.
// Inputs driven and outputs sampled on the falling edge.
module tb_lcd_rgb565_dither;

    logic       pixelClk;
    logic       resetn, ditherEn, hs, vs, de;
    logic [9:0] pixelX, pixelY;
    logic [7:0] r, g, b;
    logic       lcdHs, lcdVs, lcdDe;
    logic [4:0] lcdR, lcdB;
    logic [5:0] lcdG;

    lcd_rgb565_dither #(
        .VS_ACTIVE_LOW (1'b1),
        .HS_ACTIVE_LOW (1'b1),
        .POS_W         (10)
    ) dut (
        .pixelClk (pixelClk),
        .resetn   (resetn),
        .ditherEn (ditherEn),
        .hs       (hs),
        .vs       (vs),
        .de       (de),
        .pixelX   (pixelX),
        .pixelY   (pixelY),
        .r        (r),
        .g        (g),
        .b        (b),
        .lcdHs    (lcdHs),
        .lcdVs    (lcdVs),
        .lcdDe    (lcdDe),
        .lcdR     (lcdR),
        .lcdG     (lcdG),
        .lcdB     (lcdB)
    );

    initial pixelClk = 1'b0;
    always #15 pixelClk = ~pixelClk;

    typedef struct {
        logic       rst_n, den, hs, vs, de;
        logic [9:0] x, y;
        logic [7:0] r, g, b;
    } pix_t;

    typedef struct packed {
        logic       hs, vs, de;
        logic [4:0] R;
        logic [5:0] G;
        logic [4:0] B;
    } out_t;

    typedef struct {
        pix_t       in;
        logic [4:0] R;
        logic [5:0] G;
        logic [4:0] B;
    } vec_t;

    localparam out_t RST_OUT = out_t'{1'b1, 1'b1, 1'b0, 5'd0, 6'd0, 5'd0};

    int bayer_tb [16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};

    int   n_checks = 0;
    int   n_fail   = 0;
    out_t m_s1, m_out;
    int   m_frame;
    logic m_vs_prev;

    function automatic pix_t mk(int rst_n, int den, int h, int v, int d,
                                int x, int y, int rr, int gg, int bb);
        pix_t p;
        p.rst_n = 1'(rst_n); p.den = 1'(den);
        p.hs = 1'(h); p.vs = 1'(v); p.de = 1'(d);
        p.x = 10'(x); p.y = 10'(y);
        p.r = 8'(rr); p.g = 8'(gg); p.b = 8'(bb);
        return p;
    endfunction

    // Expected RGB565 for one pixel from the arithmetic rule with saturation
    function automatic out_t ref_pix(pix_t p, int off);
        out_t o;
        int row, col, thr, rr, gg, bb;
        o.hs = p.hs; o.vs = p.vs; o.de = p.de;
        o.R = 5'd0; o.G = 6'd0; o.B = 5'd0;
        if (p.de) begin
            row = (int'(p.y) + off) % 4;
            col = (int'(p.x) + off) % 4;
            thr = p.den ? bayer_tb[row*4 + col] : 0;
            rr  = (int'(p.r) + thr/2) / 8; if (rr > 31) rr = 31;
            gg  = (int'(p.g) + thr/4) / 4; if (gg > 63) gg = 63;
            bb  = (int'(p.b) + thr/2) / 8; if (bb > 31) bb = 31;
            o.R = 5'(rr); o.G = 6'(gg); o.B = 5'(bb);
        end
        return o;
    endfunction

    // Apply inputs for the next rising edge and advance the model by one pixel
    task automatic drive(input pix_t p);
        int   off;
        logic vs_on;
        resetn = p.rst_n; ditherEn = p.den;
        hs = p.hs; vs = p.vs; de = p.de;
        pixelX = p.x; pixelY = p.y;
        r = p.r; g = p.g; b = p.b;
`ifdef LCD_DITHER_TEMPORAL_EN
        off = m_frame;
`else
        off = 0;
`endif
        if (!p.rst_n) begin
            m_s1 = RST_OUT; m_out = RST_OUT; m_frame = 0; m_vs_prev = 1'b0;
        end else begin
            m_out = m_s1;
            m_s1  = ref_pix(p, off);
            vs_on = ~p.vs;
            if (vs_on && !m_vs_prev) m_frame = (m_frame + 1) % 4;
            m_vs_prev = vs_on;
        end
    endtask

    // Falling edge: compare the whole output bundle to the model
    task automatic tick();
        out_t act;
        @(negedge pixelClk);
        act = {lcdHs, lcdVs, lcdDe, lcdR, lcdG, lcdB};
        n_checks++;
        if (act !== m_out) begin
            n_fail++;
            $display("FAIL stream t=%0t: got hs/vs/de/R/G/B=%b/%b/%b/%h/%h/%h expected %b/%b/%b/%h/%h/%h",
                     $time, act.hs, act.vs, act.de, act.R, act.G, act.B,
                     m_out.hs, m_out.vs, m_out.de, m_out.R, m_out.G, m_out.B);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    vec_t vecs [10];
    pix_t p;

    initial begin
        m_s1 = RST_OUT; m_out = RST_OUT; m_frame = 0; m_vs_prev = 1'b0;

        // Reset with busy inputs: outputs must hold reset values
        repeat (3) begin
            drive(mk(0, 1, 0, 0, 1, 1, 0, 255, 255, 255));
            tick();
        end
        chk("rst_R", int'(lcdR), 0);
        chk("rst_G", int'(lcdG), 0);
        chk("rst_B", int'(lcdB), 0);
        chk("rst_de", int'(lcdDe), 0);
        chk("rst_hs", int'(lcdHs), 1);
        chk("rst_vs", int'(lcdVs), 1);

        // Directed vectors: mk(rst,den,hs,vs,de,x,y,r,g,b) -> R,G,B
        vecs[0] = '{mk(1,1,1,1,1, 0,0, 'h87,'h87,'h87), 5'h10, 6'h21, 5'h10};
        vecs[1] = '{mk(1,1,1,1,1, 1,0, 'h87,'h87,'h87), 5'h11, 6'h22, 5'h11};
        vecs[2] = '{mk(1,1,1,1,1, 1,0, 'hFF,'h87,'h87), 5'h1F, 6'h22, 5'h11};
        vecs[3] = '{mk(1,0,1,1,1, 3,3, 'h8F,'h8F,'h8F), 5'h11, 6'h23, 5'h11};
        vecs[4] = '{mk(1,1,1,1,0, 1,0, 'hFF,'hFF,'hFF), 5'h00, 6'h00, 5'h00};
        vecs[5] = '{mk(1,1,1,1,1, 0,0, 'h00,'hFF,'hFF), 5'h00, 6'h3F, 5'h1F};
        vecs[6] = '{mk(1,1,1,1,1, 3,3, 'h87,'h87,'h87), 5'h11, 6'h22, 5'h11};
        vecs[7] = '{mk(1,1,1,1,1, 2,1, 'h80,'h80,'h80), 5'h10, 6'h20, 5'h10};
        vecs[8] = '{mk(1,1,1,1,1, 5,4, 'h87,'h87,'h87), 5'h11, 6'h22, 5'h11};
        vecs[9] = '{mk(1,1,1,1,1, 0,3, 'hFC,'hFC,'hFC), 5'h1F, 6'h3F, 5'h1F};
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].in); tick();
            drive(vecs[i].in); tick();
            chk($sformatf("vec%0d_R", i), int'(lcdR), int'(vecs[i].R));
            chk($sformatf("vec%0d_G", i), int'(lcdG), int'(vecs[i].G));
            chk($sformatf("vec%0d_B", i), int'(lcdB), int'(vecs[i].B));
        end

        // Sync delay: a one-cycle low on hs/vs with de low appears two edges later
        drive(mk(1,1,0,0,0, 0,0, 'h87,'h87,'h87)); tick();
        drive(mk(1,1,1,1,1, 0,0, 'h87,'h87,'h87)); tick();
        chk("dly_hs0", int'(lcdHs), 0);
        chk("dly_vs0", int'(lcdVs), 0);
        chk("dly_de0", int'(lcdDe), 0);
        drive(mk(1,1,1,1,1, 0,0, 'h87,'h87,'h87)); tick();
        chk("dly_hs1", int'(lcdHs), 1);
        chk("dly_vs1", int'(lcdVs), 1);
        chk("dly_de1", int'(lcdDe), 1);

        // Reset in the middle of an active line, then recovery after two edges
        repeat (3) begin
            drive(mk(1,1,1,1,1, 1,0, 'hFF,'hFF,'hFF)); tick();
        end
        drive(mk(0,1,1,1,1, 1,0, 'hFF,'hFF,'hFF)); tick();
        chk("midrst_de", int'(lcdDe), 0);
        chk("midrst_R", int'(lcdR), 0);
        chk("midrst_hs", int'(lcdHs), 1);
        chk("midrst_vs", int'(lcdVs), 1);
        drive(mk(1,1,1,1,1, 0,0, 'h87,'h87,'h87)); tick();
        chk("rel1_de", int'(lcdDe), 0);
        drive(mk(1,1,1,1,1, 0,0, 'h87,'h87,'h87)); tick();
        chk("rel2_R", int'(lcdR), 'h10);
        chk("rel2_de", int'(lcdDe), 1);

        // Frames of a constant pixel at (0,0): vs pulse, then active pixels
        for (int f = 0; f < 8; f++) begin
            drive(mk(1,1,1,0,0, 0,0, 0,0,0)); tick();
            repeat (4) begin
                drive(mk(1,1,1,1,1, 0,0, 'h87,'h87,'h87)); tick();
            end
`ifdef LCD_DITHER_TEMPORAL_EN
            chk($sformatf("frame%0d_R", f), int'(lcdR), (f % 2 == 0) ? 'h11 : 'h10);
`else
            chk($sformatf("frame%0d_R", f), int'(lcdR), 'h10);
`endif
        end

        // Random stream with occasional resets
        for (int i = 0; i < 600; i++) begin
            p.rst_n = ($urandom_range(0, 24) != 0);
            p.den   = 1'($urandom);
            p.hs    = 1'($urandom);
            p.vs    = ($urandom_range(0, 7) != 0);
            p.de    = ($urandom_range(0, 3) != 0);
            p.x     = 10'($urandom);
            p.y     = 10'($urandom);
            p.r     = 8'($urandom);
            p.g     = 8'($urandom);
            p.b     = 8'($urandom);
            drive(p);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
